// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset defaults,
// FSM state encoding and the alignment helper.
package fetch_controller_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    DEF_RESET_PC = 64'h0;
  localparam int                 DEF_MAX_WAIT = 15;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0]    PC_INCR      = 64'd4;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_SLOT = 3'd2,
    ST_DISCARD   = 3'd3,
    ST_ERROR     = 3'd4
  } fetch_state_e;

  // Instructions are word aligned; only the two low address bits matter.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_controller_skid.sv
// One-entry {pc, instr} holding slot for an instruction that returns while
// the decode-facing output register is still occupied.
module fetch_controller_skid
  import fetch_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [XLEN-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic               valid,
  output logic [XLEN-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  // Slot storage; a redirect flush beats any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= 64'h0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      pc    <= push_pc;
      instr <= push_instr;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem
// reads, handles redirects, decode back-pressure and request timeouts.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [XLEN-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               fetch_error
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  fetch_state_e       state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [XLEN-1:0]    redirect_pc;
  logic               skid_valid;
  logic [XLEN-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               acked, consumed, out_free, timeout, redirect;
  logic               skid_push, skid_pop, skid_flush;

  assign acked      = imem_req && imem_ack;
  assign consumed   = instr_valid && !stall;
  assign out_free   = !instr_valid || consumed;
  assign timeout    = imem_req && !imem_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));
  assign redirect   = branch_taken && (state != ST_ERROR);
  assign skid_flush = redirect;
  assign skid_push  = (state == ST_FETCH) && acked && !out_free && !branch_taken && !timeout;
  assign skid_pop   = (state == ST_WAIT_SLOT) && consumed && !branch_taken;

  fetch_controller_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (skid_flush),
    .push_pc    (imem_addr),
    .push_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // Fetch FSM; errors outrank redirects, which outrank acks and stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      pc          <= 64'h0;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_error <= 1'b0;
      wait_cnt    <= '0;
      redirect_pc <= RESET_PC;
    end else if (state == ST_ERROR) begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else if (timeout || (branch_taken && !is_aligned(branch_target[1:0]))) begin
      fetch_error <= 1'b1;
      state       <= ST_ERROR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      instr_valid <= 1'b0;
      if (imem_req && !imem_ack) begin
        // The outstanding read must still complete before the redirect issues.
        state       <= ST_DISCARD;
        redirect_pc <= branch_target;
        wait_cnt    <= wait_cnt + 1'b1;
      end else begin
        state     <= ST_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= branch_target;
        wait_cnt  <= '0;
      end
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (acked) begin
            wait_cnt  <= '0;
            imem_addr <= imem_addr + PC_INCR;
            if (out_free) begin
              pc          <= imem_addr;
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
            end else begin
              state    <= ST_WAIT_SLOT;
              imem_req <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (consumed) instr_valid <= 1'b0;
          end
        end
        ST_WAIT_SLOT: begin
          if (consumed && skid_valid) begin
            pc          <= skid_pc;
            instr       <= skid_instr;
            instr_valid <= 1'b1;
            state       <= ST_FETCH;
            imem_req    <= 1'b1;
          end
        end
        ST_DISCARD: begin
          if (imem_ack) begin
            imem_addr <= redirect_pc;
            wait_cnt  <= '0;
            state     <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_ERROR;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a rule-based checker of the
// decode/imem interface running on every cycle.
module tb_fetch_controller;

  logic        clk, reset, branch_taken, stall;
  logic [63:0] branch_target;
  logic        imem_req, imem_ack;
  logic [63:0] imem_addr, pc;
  logic [31:0] imem_rdata, instr;
  logic        instr_valid, fetch_error;

  int tests = 0;
  int fails = 0;

  // Memory responder configuration
  logic mem_en;
  int   ack_lat;
  int   req_age;

  fetch_controller dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .fetch_error(fetch_error)
  );

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) req_age <= 0;
    else if (!imem_req || imem_ack) req_age <= 0;
    else req_age <= req_age + 1;
  end

  assign imem_ack   = imem_req && mem_en && (req_age >= ack_lat);
  assign imem_rdata = mem_fn(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Interface-rule checker: data integrity, in-order delivery, request hold,
  // stall hold, redirect bubble and sticky error.
  logic [63:0] exp_pc, p_addr, p_pc;
  logic [31:0] p_instr;
  logic        have_prev, p_req, p_ack, p_valid, p_stall, p_branch, p_err;

  always @(negedge clk) begin
    if (reset) begin
      have_prev = 1'b0;
      exp_pc    = 64'h0;
    end else begin
      if (instr_valid) chk("data", {32'h0, instr}, {32'h0, mem_fn(pc)});
      if (have_prev) begin
        if (p_err) begin
          chk("err_sticky", {63'h0, fetch_error}, 64'h1);
          chk("err_req", {63'h0, imem_req}, 64'h0);
          chk("err_valid", {63'h0, instr_valid}, 64'h0);
        end else if (!fetch_error) begin
          if (p_req && !p_ack) begin
            chk("req_hold", {63'h0, imem_req}, 64'h1);
            chk("addr_hold", imem_addr, p_addr);
          end
          if (p_branch) begin
            chk("branch_bubble", {63'h0, instr_valid}, 64'h0);
          end else if (p_valid && p_stall) begin
            chk("stall_valid", {63'h0, instr_valid}, 64'h1);
            chk("stall_pc", pc, p_pc);
            chk("stall_instr", {32'h0, instr}, {32'h0, p_instr});
          end
        end
      end
      if (instr_valid && !stall) begin
        chk("order", pc, exp_pc);
        exp_pc = exp_pc + 64'd4;
      end
      if (branch_taken) exp_pc = branch_target;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = instr_valid; p_stall = stall; p_pc = pc; p_instr = instr;
      p_branch = branch_taken; p_err = fetch_error;
      have_prev = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = 64'h0; stall = 1'b0;
    mem_en = 1'b1; ack_lat = 0;
    step(); step();

    // Reset values
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h13);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_err", {63'h0, fetch_error}, 64'h0);

    // 1: zero-wait stream
    reset = 1'b0;
    step();
    chk("t1_boot_req", {63'h0, imem_req}, 64'h1);
    chk("t1_boot_addr", imem_addr, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", {63'h0, instr_valid}, 64'h1);
      chk("t1_pc", pc, 64'(4 * i));
    end

    // 2: three-cycle ack latency at address 0
    ack_lat = 3;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", {63'h0, imem_req}, 64'h1);
      chk("t2_addr", imem_addr, 64'h0);
      chk("t2_no_valid", {63'h0, instr_valid}, 64'h0);
      step();
    end
    step();
    chk("t2_valid", {63'h0, instr_valid}, 64'h1);
    chk("t2_pc", pc, 64'h0);

    // 3: stall for three cycles fills the skid slot
    ack_lat = 0;
    do_reset();
    step(); step();
    stall = 1'b1;
    step();
    chk("t3_wait_req", {63'h0, imem_req}, 64'h0);
    chk("t3_hold_pc", pc, 64'h0);
    step();
    chk("t3_wait_req2", {63'h0, imem_req}, 64'h0);
    step();
    chk("t3_hold_pc2", pc, 64'h0);
    stall = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t3_valid", {63'h0, instr_valid}, 64'h1);
      chk("t3_pc", pc, 64'(4 * i));
    end

    // 4: redirect while the read to 0x8 is outstanding
    do_reset();
    step(); step(); step();
    mem_en = 1'b0;
    chk("t4_pending_addr", imem_addr, 64'h8);
    step();
    branch_taken = 1'b1; branch_target = 64'h100;
    step();
    branch_taken = 1'b0;
    mem_en = 1'b1;
    chk("t4_discard_addr", imem_addr, 64'h8);
    chk("t4_discard_valid", {63'h0, instr_valid}, 64'h0);
    step();
    chk("t4_new_addr", imem_addr, 64'h100);
    chk("t4_new_req", {63'h0, imem_req}, 64'h1);
    chk("t4_gap_valid", {63'h0, instr_valid}, 64'h0);
    step();
    chk("t4_first_valid", {63'h0, instr_valid}, 64'h1);
    chk("t4_first_pc", pc, 64'h100);

    // 5: misaligned redirect is fatal until reset
    branch_taken = 1'b1; branch_target = 64'h102;
    step();
    branch_taken = 1'b0;
    chk("t5_err", {63'h0, fetch_error}, 64'h1);
    chk("t5_req", {63'h0, imem_req}, 64'h0);
    step(); step();
    chk("t5_req_later", {63'h0, imem_req}, 64'h0);
    chk("t5_err_later", {63'h0, fetch_error}, 64'h1);
    do_reset();
    chk("t5_err_cleared", {63'h0, fetch_error}, 64'h0);

    // 6a: memory never answers -> timeout after 15 waiting cycles
    mem_en = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 14; i++) begin
      step();
      chk("t6_no_err_yet", {63'h0, fetch_error}, 64'h0);
    end
    step();
    chk("t6_timeout_err", {63'h0, fetch_error}, 64'h1);
    chk("t6_timeout_req", {63'h0, imem_req}, 64'h0);

    // 6b: address wrap, redirect taken in the same cycle as an ack
    mem_en = 1'b1;
    do_reset();
    step();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("t6_wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_wrap_bubble", {63'h0, instr_valid}, 64'h0);
    step();
    chk("t6_top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("t6_wrapped_pc", pc, 64'h0);
    chk("t6_wrap_valid", {63'h0, instr_valid}, 64'h1);
    chk("t6_wrap_no_err", {63'h0, fetch_error}, 64'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
